// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: operator codes, sequencer
// state encoding and the default datapath width.
package calc_pkg;

  localparam int CALC_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POP_OP = 4'd1;
  localparam logic [3:0] S_POP_B  = 4'd2;
  localparam logic [3:0] S_POP_A  = 4'd3;
  localparam logic [3:0] S_EXEC   = 4'd4;
  localparam logic [3:0] S_DIV    = 4'd5;
  localparam logic [3:0] S_PUSH   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

endpackage

// File: rtl/calc_div_unit.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, W steps.
// The first step happens on the go edge so done lands W cycles after go.
module calc_div_unit
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;

  // Shift the next dividend bit into the remainder; subtract when it fits.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] dvs);
    logic [W:0]   sh;
    logic [W-1:0] rem_n;
    logic         qbit;
    sh = {rem, quo[W-1]};
    if (sh >= {1'b0, dvs}) begin
      rem_n = W'(sh - {1'b0, dvs});
      qbit  = 1'b1;
    end else begin
      rem_n = sh[W-1:0];
      qbit  = 1'b0;
    end
    return {rem_n, quo[W-2:0], qbit};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy  <= 1'b0;
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
    end else if (go) begin
      {rem_r, quo_r} <= div_step('0, dividend, divisor);
      dvs_r          <= divisor;
      cnt_r          <= CW'(W - 1);
      busy           <= 1'b1;
    end else if (busy) begin
      if (cnt_r == '0) begin
        busy <= 1'b0;
      end else begin
        {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
        cnt_r          <= cnt_r - 1'b1;
      end
    end
  end

  assign done     = busy && (cnt_r == '0);
  assign quotient = quo_r;

endmodule

// File: rtl/calc_exec_seq.sv
// Execution sequencer: pops an operator and two operands, evaluates, pushes
// the result back onto the operand stack and pulses complete.
module calc_exec_seq
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_empty,
  input  logic [1:0]   op_top,
  input  logic         opnd_empty,
  input  logic [W-1:0] opnd_top,
  output logic         op_pop,
  output logic         opnd_pop,
  output logic         opnd_push,
  output logic [W-1:0] opnd_din,
  output logic         busy,
  output logic         complete,
  output logic         err
);

  logic [3:0]   state_r;
  logic [3:0]   state_nx;
  logic [1:0]   op_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] res_r;
  logic         err_r;

  logic         div_go;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_q;

  assign div_go = (state_r == S_EXEC) && (op_r == OP_DIV) && (b_r != '0);

  calc_div_unit #(.W(W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend (a_r),
    .divisor  (b_r),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE:   if (start) state_nx = S_POP_OP;
      S_POP_OP: state_nx = op_empty   ? S_ERR : S_POP_B;
      S_POP_B:  state_nx = opnd_empty ? S_ERR : S_POP_A;
      S_POP_A:  state_nx = opnd_empty ? S_ERR : S_EXEC;
      S_EXEC:   state_nx = div_go ? S_DIV : S_PUSH;
      // A divider that is not running can never finish, so leave rather than hang.
      S_DIV:    if (div_done || !div_busy) state_nx = S_PUSH;
      S_PUSH:   state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx;
      case (state_r)
        S_IDLE:   if (start) err_r <= 1'b0;
        S_POP_OP: if (op_empty) err_r <= 1'b1; else op_r <= op_top;
        S_POP_B:  if (opnd_empty) err_r <= 1'b1; else b_r <= opnd_top;
        S_POP_A:  if (opnd_empty) err_r <= 1'b1; else a_r <= opnd_top;
        S_EXEC: begin
          case (op_r)
            OP_ADD: res_r <= a_r + b_r;
            OP_SUB: res_r <= a_r - b_r;
            OP_MUL: res_r <= a_r * b_r;
            default: begin
              if (b_r == '0) begin
                err_r <= 1'b1;
                res_r <= '0;
              end
            end
          endcase
        end
        S_DIV:    if (div_done) res_r <= div_q;
        default:  ;
      endcase
    end
  end

  assign op_pop    = (state_r == S_POP_OP) && !op_empty;
  assign opnd_pop  = ((state_r == S_POP_B) || (state_r == S_POP_A)) && !opnd_empty;
  assign opnd_push = (state_r == S_PUSH);
  assign opnd_din  = res_r;
  assign busy      = (state_r != S_IDLE);
  assign complete  = (state_r == S_DONE) || (state_r == S_ERR);
  assign err       = err_r;

endmodule
